// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: round-robin arbiter granting one port a whole multi-beat packet at a time
module rr_port_arbiter #(
  parameter int num_ports = 8,
  parameter int width     = $clog2(num_ports)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [num_ports-1:0] req_i,
  input  logic [num_ports-1:0] eop_i,
  input  logic                 ready_i,
  output logic [num_ports-1:0] grant_o,
  output logic [width-1:0]     grant_id_o,
  output logic                 grant_valid_o
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t               state_q, state_d;
  logic [width-1:0]     last_q, last_d, id_q, id_d, pick;
  logic [num_ports-1:0] grant_q, grant_d, mask, hi;
  logic                 xfer;
  function automatic logic [width-1:0] lsb(input logic [num_ports-1:0] v);
    lsb = '0;
    for (int i = num_ports - 1; i >= 0; i--)
      if (v[i]) lsb = width'(i);
  endfunction
  // thermometer of the last winner: ports strictly above it are favoured
  always_comb begin
    for (int i = 0; i < num_ports; i++) mask[i] = i <= int'(last_q);
  end
  assign hi   = req_i & ~mask;
  assign pick = |hi ? lsb(hi) : lsb(req_i);
  assign xfer = state_q == LOCKED && ready_i && req_i[id_q];
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    grant_d = grant_q;
    if (state_q == IDLE && |req_i) begin
      state_d = LOCKED;
      id_d    = pick;
      grant_d = {{(num_ports-1){1'b0}}, 1'b1} << pick;
    end else if (xfer && eop_i[id_q]) begin
      state_d = IDLE;
      last_d  = id_q;
      id_d    = '0;
      grant_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= width'(num_ports - 1);
      id_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      grant_q <= grant_d;
    end
  end
  assign grant_o       = grant_q;
  assign grant_id_o    = id_q;
  assign grant_valid_o = state_q == LOCKED;
endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb_rr_port_arbiter: directed plan plus random traffic against a cyclic-search packet model
module tb_rr_port_arbiter;
  localparam int np = 8;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [np-1:0] req = '0, eop = '0;
  logic          ready = 1'b0;
  logic [np-1:0] grant;
  logic [2:0]    gid;
  logic          gv;
  int            n_cmp = 0, n_err = 0;
  bit            m_locked = 1'b0;
  int            m_owner = 0, m_last = np - 1;

  rr_port_arbiter #(.num_ports(np)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .eop_i(eop), .ready_i(ready),
    .grant_o(grant), .grant_id_o(gid), .grant_valid_o(gv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input logic [np-1:0] r, input logic [np-1:0] e, input logic rd);
    req = r; eop = e; ready = rd;
    @(negedge clk);
  endtask

  task automatic chk_g(input string name, input logic [np-1:0] g, input int id, input logic v);
    chk({name, ".grant"}, 32'(grant), 32'(g));
    chk({name, ".grant_id"}, 32'(gid), 32'(id));
    chk({name, ".grant_valid"}, 32'(gv), 32'(v));
  endtask

  // model: a packet owner is chosen by cyclic search starting after the last winner
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_locked = 1'b0;
      m_last   = np - 1;
    end else if (!m_locked) begin
      for (int k = 1; k <= np; k++)
        if (!m_locked && req[(m_last + k) % np]) begin
          m_locked = 1'b1;
          m_owner  = (m_last + k) % np;
        end
    end else if (ready && req[m_owner] && eop[m_owner]) begin
      m_locked = 1'b0;
      m_last   = m_owner;
    end
    #1;
    chk("model.grant", 32'(grant), m_locked ? 32'(1) << m_owner : 32'd0);
    chk("model.grant_id", 32'(gid), m_locked ? 32'(m_owner) : 32'd0);
    chk("model.grant_valid", 32'(gv), 32'(m_locked));
  end

  initial begin
    @(negedge clk);
    tick(8'hFF, 8'h00, 1'b0);
    tick(8'hFF, 8'h00, 1'b0);
    chk_g("reset_hold", 8'h00, 0, 1'b0);
    rst_n = 1'b1;
    tick(8'hFF, 8'h00, 1'b0);
    chk_g("reset_release", 8'h01, 0, 1'b1);
    tick(8'hFF, 8'hFF, 1'b1);
    chk_g("rot_release0", 8'h00, 0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(8'hFF, 8'hFF, 1'b1);
      chk("rot.id", 32'(gid), 32'(k % 8));
      tick(8'hFF, 8'hFF, 1'b1);
      chk("rot.bubble", 32'(gv), 32'd0);
    end
    tick(8'h28, 8'h00, 1'b0);
    chk_g("lock.start", 8'h08, 3, 1'b1);
    tick(8'h28, 8'h00, 1'b1);
    tick(8'h28, 8'h00, 1'b0);
    tick(8'h28, 8'h00, 1'b1);
    tick(8'h28, 8'h00, 1'b0);
    tick(8'h28, 8'h00, 1'b1);
    chk_g("lock.held", 8'h08, 3, 1'b1);
    tick(8'h28, 8'h08, 1'b1);
    chk_g("lock.gap", 8'h00, 0, 1'b0);
    tick(8'h20, 8'h00, 1'b0);
    chk_g("lock.next", 8'h20, 5, 1'b1);
    tick(8'h20, 8'h20, 1'b1);
    tick(8'h40, 8'h00, 1'b0);
    chk_g("wrap.p6", 8'h40, 6, 1'b1);
    tick(8'h40, 8'h40, 1'b1);
    tick(8'h41, 8'h00, 1'b0);
    chk_g("wrap.p0", 8'h01, 0, 1'b1);
    tick(8'h41, 8'h01, 1'b1);
    tick(8'h41, 8'h00, 1'b0);
    chk_g("wrap.p6b", 8'h40, 6, 1'b1);
    tick(8'h41, 8'h40, 1'b1);
    tick(8'h02, 8'h00, 1'b0);
    tick(8'h02, 8'h02, 1'b1);
    tick(8'h06, 8'h00, 1'b0);
    chk_g("stall.lock", 8'h04, 2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(8'h02, 8'h02, 1'b1);
      chk_g("stall.held", 8'h04, 2, 1'b1);
    end
    tick(8'h06, 8'h04, 1'b1);
    chk_g("stall.release", 8'h00, 0, 1'b0);
    tick(8'h02, 8'h00, 1'b0);
    chk_g("stall.p1", 8'h02, 1, 1'b1);
    tick(8'h02, 8'h02, 1'b1);
    tick(8'h10, 8'h00, 1'b0);
    chk_g("midrst.lock", 8'h10, 4, 1'b1);
    tick(8'h10, 8'h00, 1'b1);
    tick(8'h10, 8'h00, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_g("midrst.async", 8'h00, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(8'h90, 8'h00, 1'b0);
    chk_g("midrst.after", 8'h10, 4, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick(8'($urandom), 8'($urandom), 1'b1);
        rst_n = 1'b1;
      end else begin
        tick(8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom), $urandom_range(0, 3) != 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
